elevator_motor_controller: RTL and testbench
============================================

Name: elevator_motor_controller

Overview:
- Elevator car controller. Latches floor requests, schedules car movement, times floor-to-floor travel and door dwell, and handles emergency stop.
- Produces the 2-bit motor state code consumed directly by the downstream motor-state 7-segment decoder: 00 parado, 01 subindo, 10 descendo, 11 erro.
- Also exports current floor, door status and pending-request mask for board LEDs/HEX.

Parameters:
- NUM_FLOORS, 4, number of floors (2..16); floors numbered 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 50_000_000, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 100_000_000, clock cycles the door stays open (>=1).
- FW, $clog2(NUM_FLOORS), floor index width (derived; do not override).

Ports:
- CLOCK_50  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_FLOORS  floor call buttons; bit i high for any cycle requests floor i.
- estop  input  1  emergency stop, level; sampled each cycle.
- motor  output  2  motor state: 00 parado, 01 subindo, 10 descendo, 11 erro.
- floor  output  FW  current/last-reached floor.
- door_open  output  1  high while door dwell active.
- pending  output  NUM_FLOORS  latched unserved requests.

Behaviour:
- Reset (synchronous, active-high; one clock is the only clock) has top priority and wins from any state, including mid-travel.
  - Reset values: state IDLE, motor=00, floor=0, door_open=0, pending=0, dir=UP, all timers 0.
  - Car is assumed at floor 0 after reset.
- All outputs are registered.
- pending update each cycle: pending <= (pending | req) & ~served.
  - served = one-hot of the floor being entered/held in DOOR_OPEN this edge.
  - A req bit for a floor being served in the same edge is dropped (treated as served).
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ERROR.
- IDLE (motor=00). Decisions use registered pending only (one-cycle decision latency).
  - pending[floor]=1 -> DOOR_OPEN, clear bit.
  - Else if there is a request in the current dir: go that way (MOVE_UP if dir=UP and any bit above floor; MOVE_DOWN if dir=DOWN and any bit below).
  - Else if there is a request in the opposite dir: reverse, i.e. set dir and move.
  - Else stay IDLE.
- MOVE_UP (motor=01) / MOVE_DOWN (motor=10):
  - Travel timer counts 0..TRAVEL_CYCLES-1.
  - On terminal count: floor +1 / -1 and timer clears.
  - If pending (incl. same-cycle req) has the new floor -> DOOR_OPEN and clear that bit in the same edge.
  - Otherwise, if any request remains beyond the new floor in the current dir, continue; else -> IDLE.
  - floor never exceeds NUM_FLOORS-1 or goes below 0. An attempted out-of-range step -> ERROR (defensive; unreachable in correct RTL).
- DOOR_OPEN (motor=00, door_open=1):
  - Dwell timer counts DOOR_CYCLES cycles, then -> IDLE with door_open=0.
  - req for the current floor during dwell restarts the dwell timer and is not latched.
- ERROR (motor=11, door_open=0): entered the cycle after estop=1 is sampled, from any state.
  - pending cleared and floor frozen on entry.
  - Sticky: exits only via reset; estop deasserting does not exit.
- Priority per edge: reset > estop > arrival/dwell expiry > request latching.
- Timers sized $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1) bits; no wrap in normal operation.

Test Plan:
(Simulation parameters for all scenarios: NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3.)
- Reset then idle 10 cycles -> motor=00, floor=0, door_open=0, pending=0000 throughout.
- Pulse req=0100 for 1 cycle at floor 0:
  - pending=0100 next cycle; motor=01 the cycle after, held exactly 8 cycles.
  - floor then reads 1 then 2; on arrival motor=00, door_open=1 for 3 cycles, pending=0000, then IDLE.
- At floor 2 idle, req=1001 same cycle with dir=UP -> serves 3 first (motor=01, 4 cycles), door dwell, then motor=10 for 12 cycles to floor 0, door dwell.
- At floor 1 in DOOR_OPEN, req=0010 on 2nd dwell cycle -> dwell restarts; door_open high 3 cycles from that point; pending stays 0000.
- estop=1 for 1 cycle mid MOVE_UP -> next cycle motor=11, pending=0000, floor frozen; remains 11 after estop drops, including with new req pulses; reset -> motor=00, floor=0.
- reset asserted mid-travel at timer=2 -> next cycle all outputs at reset values; a subsequent req=0001 -> immediate DOOR_OPEN at floor 0, with no motor movement.

Source files
------------

// File: rtl/elevator_motor_controller.sv
// Purpose : elevator car controller - latches floor calls, schedules travel, times doors, handles emergency stop.
// Latency : all outputs registered; idle decisions act on the registered request mask one cycle after it latches.
// Backpres: none; call buttons are sampled every cycle and OR'd into the pending mask, so no call is ever refused.
//
// Ports:
//   CLOCK_50  - system clock, all state on the rising edge
//   reset     - synchronous active-high reset, wins over everything
//   req       - floor call buttons, bit i requests floor i
//   estop     - emergency stop level; sends the car to a sticky error state
//   motor     - 00 stopped, 01 going up, 10 going down, 11 error
//   floor     - current / last-reached floor
//   door_open - high while the door dwell is running
//   pending   - latched, not yet served requests
module elevator_motor_controller #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int FW            = $clog2(NUM_FLOORS)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  estop,
  output logic [1:0]            motor,
  output logic [FW-1:0]         floor,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic                    dir_q, dir_d;        // 1 = up, 0 = down
  logic [TW-1:0]           timer_q, timer_d;    // shared travel / dwell timer
  logic [FW-1:0]           floor_d, nf;
  logic [NUM_FLOORS-1:0]   pending_d, served, pend_all;
  logic [1:0]              motor_d;
  logic                    door_d;

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FW-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && m[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && m[i]) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    floor_d  = floor;
    nf       = floor;
    served   = '0;
    // arrival decisions may use a call pressed on the very edge of arrival
    pend_all = pending | req;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pending[floor]) begin
          state_d = S_DOOR_OPEN;
          served  = onehot(floor);
        end else if (dir_q && any_above(pending, floor)) begin
          state_d = S_MOVE_UP;
        end else if (!dir_q && any_below(pending, floor)) begin
          state_d = S_MOVE_DOWN;
        end else if (any_above(pending, floor)) begin
          state_d = S_MOVE_UP;
          dir_d   = 1'b1;
        end else if (any_below(pending, floor)) begin
          state_d = S_MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          if ((state_q == S_MOVE_UP && floor == TOP_FLOOR) ||
              (state_q == S_MOVE_DOWN && floor == '0)) begin
            // stepping off the end of the shaft means the schedule is corrupt
            state_d = S_ERROR;
          end else begin
            nf      = (state_q == S_MOVE_UP) ? floor + 1'b1 : floor - 1'b1;
            floor_d = nf;
            if (pend_all[nf]) begin
              state_d = S_DOOR_OPEN;
              served  = onehot(nf);
            end else if (state_q == S_MOVE_UP ? !any_above(pend_all, nf)
                                              : !any_below(pend_all, nf)) begin
              state_d = S_IDLE;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DOOR_OPEN: begin
        // a call for this floor while the door is open just holds it open
        served = onehot(floor);
        if (req[floor]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_ERROR: state_d = S_ERROR;

      default: state_d = S_ERROR;
    endcase

    if (estop) begin
      state_d = S_ERROR;
      floor_d = floor;
      timer_d = '0;
    end

    // error state holds the request mask empty
    pending_d = (state_d == S_ERROR) ? '0 : (pend_all & ~served);

    case (state_d)
      S_MOVE_UP:   motor_d = 2'b01;
      S_MOVE_DOWN: motor_d = 2'b10;
      S_ERROR:     motor_d = 2'b11;
      default:     motor_d = 2'b00;
    endcase
    door_d = (state_d == S_DOOR_OPEN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b1;
      timer_q   <= '0;
      floor     <= '0;
      pending   <= '0;
      motor     <= 2'b00;
      door_open <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      floor     <= floor_d;
      pending   <= pending_d;
      motor     <= motor_d;
      door_open <= door_d;
    end
  end

endmodule

// File: tb/tb_elevator_motor_controller.sv
module tb_elevator_motor_controller;

  localparam int NF     = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] req = '0;
  logic          estop = 1'b0;
  logic [1:0]    motor;
  logic [1:0]    floor;
  logic          door_open;
  logic [NF-1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  elevator_motor_controller #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOOR)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .req(req),
    .estop(estop),
    .motor(motor),
    .floor(floor),
    .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // Car described by position, signed travel direction and cycles left of the
  // current travel step / door dwell.
  int          m_floor;
  bit          m_up;
  bit          m_err;
  int          m_move;   // +1 up, -1 down, 0 stopped
  int          m_tl;     // cycles left in the current floor-to-floor step
  int          m_dl;     // door cycles left, door open while > 0
  logic [NF-1:0] m_pend;

  function automatic bit beyond(input logic [NF-1:0] p, input int f, input int d);
    logic [NF-1:0] lowmask;
    lowmask = (NF'(1) << f) - NF'(1);
    if (d > 0) return (p >> (f + 1)) != '0;
    return (p & lowmask) != '0;
  endfunction

  task automatic model_step(input logic [NF-1:0] rq, input bit es, input bit rs);
    logic [NF-1:0] all;
    int dirn;
    if (rs) begin
      m_floor = 0; m_up = 1; m_err = 0; m_move = 0; m_tl = 0; m_dl = 0; m_pend = '0;
    end else if (m_err) begin
      m_pend = '0;
    end else if (es) begin
      m_err = 1; m_pend = '0; m_move = 0; m_dl = 0;
    end else begin
      all = m_pend | rq;
      if (m_dl > 0) begin
        all[m_floor] = 1'b0;
        if (rq[m_floor]) m_dl = DOOR;
        else m_dl = m_dl - 1;
      end else if (m_move != 0) begin
        m_tl = m_tl - 1;
        if (m_tl == 0) begin
          m_floor = m_floor + m_move;
          if (all[m_floor]) begin
            all[m_floor] = 1'b0; m_move = 0; m_dl = DOOR;
          end else if (beyond(all, m_floor, m_move)) begin
            m_tl = TRAVEL;
          end else begin
            m_move = 0;
          end
        end
      end else begin
        dirn = m_up ? 1 : -1;
        if (m_pend[m_floor]) begin
          all[m_floor] = 1'b0; m_dl = DOOR;
        end else if (beyond(m_pend, m_floor, dirn)) begin
          m_move = dirn; m_tl = TRAVEL;
        end else if (beyond(m_pend, m_floor, -dirn)) begin
          m_up = !m_up; m_move = -dirn; m_tl = TRAVEL;
        end
      end
      m_pend = all;
    end
  endtask

  // ---------------- drive / compare ----------------
  task automatic apply_vec(input logic [NF-1:0] rq, input bit es, input bit rs);
    req = rq; estop = es; reset = rs;
    @(posedge clk);
    #1;
    model_step(rq, es, rs);
  endtask

  task automatic check_out(input string name, input logic [1:0] em, input int ef,
                           input bit ed, input logic [NF-1:0] ep);
    vectors++;
    if (motor !== em || int'(floor) != ef || door_open !== ed || pending !== ep) begin
      miscompares++;
      $display("FAIL %s @%0t: got motor=%b floor=%0d door=%b pending=%b, want motor=%b floor=%0d door=%b pending=%b",
               name, $time, motor, floor, door_open, pending, em, ef, ed, ep);
    end
  endtask

  task automatic step_chk(input string name, input logic [NF-1:0] rq, input bit es, input bit rs,
                          input logic [1:0] em, input int ef, input bit ed, input logic [NF-1:0] ep);
    apply_vec(rq, es, rs);
    check_out(name, em, ef, ed, ep);
  endtask

  typedef struct {
    logic [NF-1:0] rq;
    bit            es;
    bit            rs;
    logic [1:0]    m;
    int            f;
    bit            d;
    logic [NF-1:0] p;
  } vec_t;

  vec_t tbl[$];

  function automatic void addn(input int n, input logic [NF-1:0] rq, input bit es, input bit rs,
                               input logic [1:0] m, input int f, input bit d, input logic [NF-1:0] p);
    vec_t v;
    v.rq = rq; v.es = es; v.rs = rs; v.m = m; v.f = f; v.d = d; v.p = p;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    logic [NF-1:0] rq;
    bit es, rs;

    // reset and idle
    addn(1,  4'b0000, 0, 1, 2'b00, 0, 0, 4'b0000);
    addn(10, 4'b0000, 0, 0, 2'b00, 0, 0, 4'b0000);
    // call floor 2 from floor 0: 8 cycles up, 3 cycles door
    addn(1,  4'b0100, 0, 0, 2'b00, 0, 0, 4'b0100);
    addn(4,  4'b0000, 0, 0, 2'b01, 0, 0, 4'b0100);
    addn(4,  4'b0000, 0, 0, 2'b01, 1, 0, 4'b0100);
    addn(3,  4'b0000, 0, 0, 2'b00, 2, 1, 4'b0000);
    addn(1,  4'b0000, 0, 0, 2'b00, 2, 0, 4'b0000);
    // calls 3 and 0 together at floor 2 heading up: 3 first, then down to 0
    addn(1,  4'b1001, 0, 0, 2'b00, 2, 0, 4'b1001);
    addn(4,  4'b0000, 0, 0, 2'b01, 2, 0, 4'b1001);
    addn(3,  4'b0000, 0, 0, 2'b00, 3, 1, 4'b0001);
    addn(1,  4'b0000, 0, 0, 2'b00, 3, 0, 4'b0001);
    addn(4,  4'b0000, 0, 0, 2'b10, 3, 0, 4'b0001);
    addn(4,  4'b0000, 0, 0, 2'b10, 2, 0, 4'b0001);
    addn(4,  4'b0000, 0, 0, 2'b10, 1, 0, 4'b0001);
    addn(3,  4'b0000, 0, 0, 2'b00, 0, 1, 4'b0000);
    addn(1,  4'b0000, 0, 0, 2'b00, 0, 0, 4'b0000);
    // up to floor 1 (reversal from DOWN), dwell restart on 2nd dwell cycle
    addn(1,  4'b0010, 0, 0, 2'b00, 0, 0, 4'b0010);
    addn(4,  4'b0000, 0, 0, 2'b01, 0, 0, 4'b0010);
    addn(2,  4'b0000, 0, 0, 2'b00, 1, 1, 4'b0000);
    addn(1,  4'b0010, 0, 0, 2'b00, 1, 1, 4'b0000);
    addn(2,  4'b0000, 0, 0, 2'b00, 1, 1, 4'b0000);
    addn(1,  4'b0000, 0, 0, 2'b00, 1, 0, 4'b0000);

    foreach (tbl[i])
      step_chk($sformatf("table[%0d]", i), tbl[i].rq, tbl[i].es, tbl[i].rs,
               tbl[i].m, tbl[i].f, tbl[i].d, tbl[i].p);

    // estop mid-travel: sticky error, floor frozen, calls ignored until reset
    step_chk("estop_call",    4'b1000, 0, 0, 2'b00, 1, 0, 4'b1000);
    step_chk("estop_move0",   4'b0000, 0, 0, 2'b01, 1, 0, 4'b1000);
    step_chk("estop_move1",   4'b0000, 0, 0, 2'b01, 1, 0, 4'b1000);
    step_chk("estop_hit",     4'b0000, 1, 0, 2'b11, 1, 0, 4'b0000);
    step_chk("estop_dropped", 4'b0000, 0, 0, 2'b11, 1, 0, 4'b0000);
    step_chk("estop_req0",    4'b0001, 0, 0, 2'b11, 1, 0, 4'b0000);
    step_chk("estop_req3",    4'b1000, 0, 0, 2'b11, 1, 0, 4'b0000);
    step_chk("estop_hold",    4'b0000, 0, 0, 2'b11, 1, 0, 4'b0000);
    step_chk("estop_reset",   4'b0000, 0, 1, 2'b00, 0, 0, 4'b0000);

    // reset mid-travel at timer=2, then a call at floor 0 opens the door in place
    step_chk("rst_call",  4'b0100, 0, 0, 2'b00, 0, 0, 4'b0100);
    step_chk("rst_t0",    4'b0000, 0, 0, 2'b01, 0, 0, 4'b0100);
    step_chk("rst_t1",    4'b0000, 0, 0, 2'b01, 0, 0, 4'b0100);
    step_chk("rst_t2",    4'b0000, 0, 0, 2'b01, 0, 0, 4'b0100);
    step_chk("rst_hit",   4'b0000, 0, 1, 2'b00, 0, 0, 4'b0000);
    step_chk("rst_req0",  4'b0001, 0, 0, 2'b00, 0, 0, 4'b0001);
    step_chk("rst_door0", 4'b0000, 0, 0, 2'b00, 0, 1, 4'b0000);
    step_chk("rst_door1", 4'b0000, 0, 0, 2'b00, 0, 1, 4'b0000);
    step_chk("rst_door2", 4'b0000, 0, 0, 2'b00, 0, 1, 4'b0000);
    step_chk("rst_idle",  4'b0000, 0, 0, 2'b00, 0, 0, 4'b0000);

    // randomized traffic against the reference model
    apply_vec('0, 0, 1);
    check_out("rand_reset", 2'b00, 0, 0, 4'b0000);
    for (int n = 0; n < 4000; n++) begin
      rq = ($urandom_range(0, 99) < 15) ? NF'($urandom_range(1, 15)) : '0;
      es = ($urandom_range(0, 299) == 0);
      rs = m_err ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 599) == 0);
      apply_vec(rq, es, rs);
      check_out($sformatf("rand[%0d]", n),
                m_err ? 2'b11 : (m_move > 0 ? 2'b01 : (m_move < 0 ? 2'b10 : 2'b00)),
                m_floor, (!m_err && m_dl > 0), m_pend);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
